// File: rtl/multicycle_sequencer_if.sv
// Decoder-to-sequencer bundle: per-stage cycle counts and controls in, one-hot
// stage and timing flags out.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 2
);
  logic [CNT_W-1:0] extra_id;
  logic [CNT_W-1:0] extra_mem;
  logic [CNT_W-1:0] extra_wb;
  logic             skip_mem;
  logic             stall;
  logic             halt_req;
  logic             wake;
  logic [6:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic             last_cycle;
  logic             instr_done;

  modport master (
    output extra_id, extra_mem, extra_wb, skip_mem, stall, halt_req, wake,
    input  state, cycle_count, last_cycle, instr_done
  );

  modport slave (
    input  extra_id, extra_mem, extra_wb, skip_mem, stall, halt_req, wake,
    output state, cycle_count, last_cycle, instr_done
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Instruction sequencer: RESET, IF, ID, EX, MEM, WB with variable-length ID/MEM/WB,
// global stall, MEM bypass and a HALT sleep state.
module multicycle_sequencer #(
  parameter int CNT_W = 2
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_sequencer_if.slave bus
);

  typedef enum logic [6:0] {
    S_RESET = 7'b0000001,
    S_IF    = 7'b0000010,
    S_ID    = 7'b0000100,
    S_EX    = 7'b0001000,
    S_MEM   = 7'b0010000,
    S_WB    = 7'b0100000,
    S_HALT  = 7'b1000000
  } state_e;

  // Held as a raw vector so a corrupted (non-one-hot) value is representable and recoverable.
  logic [6:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_extra;
  logic             last_cycle;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cur_extra = '0;
    case (state_q)
      S_ID:    cur_extra = bus.extra_id;
      S_MEM:   cur_extra = bus.extra_mem;
      S_WB:    cur_extra = bus.extra_wb;
      default: cur_extra = '0;
    endcase
  end

  // Wake overrides stall while sleeping.
  assign last_cycle = state_q[6] ? bus.wake : (!bus.stall && (cnt_q == cur_extra));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT: begin
        if (last_cycle) begin
          cnt_d = '0;
          case (state_q)
            S_RESET: state_d = S_IF;
            S_IF:    state_d = S_ID;
            S_ID:    state_d = S_EX;
            S_EX:    state_d = bus.skip_mem ? S_WB : S_MEM;
            S_MEM:   state_d = S_WB;
            S_WB:    state_d = bus.halt_req ? S_HALT : S_IF;
            default: state_d = S_IF;
          endcase
        end else if (!bus.stall && !state_q[6]) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.cycle_count = cnt_q;
  assign bus.last_cycle  = last_cycle;
  assign bus.instr_done  = last_cycle && state_q[5];

endmodule
